pla_sweep_controller: RTL and testbench
=======================================

Name: pla_sweep_controller

Overview:
Self-test sequencer for the 4-input, 2-output PLA blocks (inputs A,B,C,D; outputs Y,Z). On start it latches a 16-entry expected truth table for each output, then drives all 16 input vectors into the PLA in order. After each vector it waits a programmable settle time, samples Y and Z, and compares them against the table. It reports the mismatch count, the first failing vector, the full captured truth tables, and pass/done status. It sits between a PLA instance and the lab-board/host control logic.

Parameters:
SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling Y/Z (0 allowed)
CNT_W, 4, width of settle counter; must hold SETTLE_CYCLES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE or DONE
abort  input  1  cancel sweep; returns to IDLE
exp_y  input  16  expected Y; bit v = Y for vector v
exp_z  input  16  expected Z; bit v = Z for vector v
pla_in  output  4  vector to PLA: bit3=A, bit2=B, bit1=C, bit0=D (registered)
pla_y  input  1  PLA output Y
pla_z  input  1  PLA output Z
busy  output  1  high while sweeping
done  output  1  level; high from sweep end until next start/abort
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  5  number of vectors with Y or Z mismatch (0..16)
first_fail_valid  output  1  at least one mismatch recorded
first_fail_vec  output  4  lowest-index failing vector
cap_y  output  16  captured Y truth table
cap_z  output  16  captured Z truth table

Behaviour:
- Reset (async, rst_n=0): state IDLE; pla_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, cap_y=0, cap_z=0, internal index v=0. Asserting reset mid-sweep applies these values immediately.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1 and abort=0: latch exp_y/exp_z; clear err_count, first_fail*, cap_y, cap_z, done, pass; set v=0, busy=1; go to APPLY.
- APPLY (1 cycle): pla_in<=v; load settle counter with SETTLE_CYCLES; go to SETTLE, or to SAMPLE if SETTLE_CYCLES==0.
- SETTLE: decrement the counter each cycle; move to SAMPLE on the cycle the counter reaches 1 (exactly SETTLE_CYCLES cycles are spent here).
- SAMPLE (1 cycle): cap_y[v]<=pla_y and cap_z[v]<=pla_z.
  - Mismatch when pla_y!=latched exp_y[v] or pla_z!=latched exp_z[v]. Either output wrong counts as a single error for that vector.
  - On mismatch: err_count+1. If first_fail_valid==0, set first_fail_vec=v and first_fail_valid=1.
  - If v==15, go to DONE. Otherwise v+1 and go to APPLY. v never wraps within a sweep.
- DONE: busy=0, done=1, pass=(err_count==0). Results hold until the next start.
- Latency: 16*(SETTLE_CYCLES+2) cycles from the start-accept edge to done=1. This is 64 cycles at the default setting.
- start while busy: ignored.
- abort while busy: next state IDLE; busy=0, done=0, pass=0; partial cap_*/err_count retained.
- start and abort in the same cycle: abort wins.
- pla_y/pla_z are sampled only in SAMPLE; X on them at other times is ignored.
- err_count is 5 bits so that 16 errors cannot overflow; no saturation logic is needed.

Test Plan:
- Golden PLA (Y=1 at vectors 0,11,15; Z=1 at 5,14), exp_y=16'h8801, exp_z=16'h4020, pulse start -> done rises 64 cycles later, pass=1, err_count=0, cap_y=16'h8801, cap_z=16'h4020, first_fail_valid=0.
- PLA model with Y stuck-at-0, same expectations -> err_count=3, first_fail_vec=0, first_fail_valid=1, pass=0, cap_y=16'h0000, cap_z=16'h4020.
- Swapped Y/Z model -> err_count=5 (vectors 0,5,11,14,15), first_fail_vec=0; pla_in observed stepping 0..15, each held SETTLE_CYCLES+2 cycles.
- abort asserted 20 cycles into a sweep -> IDLE next cycle, busy=0, done=0; start pressed again -> full sweep runs and passes.
- rst_n pulled low mid-sweep at vector 7 -> all outputs return to reset values at once. start pressed during busy -> no restart; sweep completes at the original cycle count.
- SETTLE_CYCLES=0 build, golden PLA -> done 32 cycles after start, pass=1.

Source files
------------

// File: rtl/pla_sweep_controller.sv
// -----------------------------------------------------------------------------
// pla_sweep_controller
//
// Self-test sequencer for a 4-input / 2-output PLA. On start it latches the
// expected Y/Z truth tables and then walks all 16 input vectors (A,B,C,D =
// pla_in[3:0]) into the PLA. Each vector is held for SETTLE_CYCLES idle
// cycles, then Y/Z are sampled, captured and compared against the tables.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            begin a sweep (honoured in IDLE or DONE, abort low)
//   abort            cancel the current sweep, return to IDLE
//   exp_y, exp_z     expected truth tables, bit v = output for vector v
//   pla_in           registered vector driven into the PLA
//   pla_y, pla_z     PLA outputs, only looked at in SAMPLE
//   busy             high while a sweep is running
//   done             level, high from sweep end until next start/abort
//   pass             valid with done, 1 iff no vector mismatched
//   err_count        number of mismatching vectors (0..16)
//   first_fail_valid at least one mismatch recorded
//   first_fail_vec   lowest-index failing vector
//   cap_y, cap_z     captured truth tables
// -----------------------------------------------------------------------------
module pla_sweep_controller #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_y,
    input  logic [15:0] exp_z,
    output logic [3:0]  pla_in,
    input  logic        pla_y,
    input  logic        pla_z,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic        first_fail_valid,
    output logic [3:0]  first_fail_vec,
    output logic [15:0] cap_y,
    output logic [15:0] cap_z
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [3:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_exp_y;
    logic [15:0]      r_exp_z;
    logic [3:0]       r_pla_in;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [4:0]       r_err_count;
    logic             r_ff_valid;
    logic [3:0]       r_ff_vec;
    logic [15:0]      r_cap_y;
    logic [15:0]      r_cap_z;

    // Either output wrong on the current vector counts as one error.
    logic w_mismatch;
    assign w_mismatch = (pla_y != r_exp_y[r_vec]) || (pla_z != r_exp_z[r_vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec       <= 4'd0;
            r_cnt       <= '0;
            r_exp_y     <= 16'd0;
            r_exp_z     <= 16'd0;
            r_pla_in    <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 5'd0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= 4'd0;
            r_cap_y     <= 16'd0;
            r_cap_z     <= 16'd0;
        end else if (abort) begin
            // Abort beats start; partial captures and error count are kept.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_exp_y     <= exp_y;
                        r_exp_z     <= exp_z;
                        r_err_count <= 5'd0;
                        r_ff_valid  <= 1'b0;
                        r_ff_vec    <= 4'd0;
                        r_cap_y     <= 16'd0;
                        r_cap_z     <= 16'd0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_vec       <= 4'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    r_pla_in <= r_vec;
                    r_cnt    <= SETTLE_LOAD;
                    r_state  <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                end

                S_SETTLE: begin
                    // Leaving when the count is 1 spends exactly SETTLE_CYCLES
                    // cycles in this state.
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    r_cap_y[r_vec] <= pla_y;
                    r_cap_z[r_vec] <= pla_z;
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + 5'd1;
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_vec   <= r_vec;
                        end
                    end
                    if (r_vec == 4'd15) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        // Final verdict must include this last vector's result.
                        r_pass  <= (r_err_count == 5'd0) && !w_mismatch;
                    end else begin
                        r_vec   <= r_vec + 4'd1;
                        r_state <= S_APPLY;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pla_in           = r_pla_in;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;
    assign cap_y            = r_cap_y;
    assign cap_z            = r_cap_z;

endmodule

// File: tb/tb_pla_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_pla_sweep_controller
//
// Directed bench for pla_sweep_controller. A behavioural PLA model (golden,
// Y stuck-at-0, or Y/Z swapped) feeds the main instance; a second instance
// built with SETTLE_CYCLES=0 is driven by its own golden model.
// -----------------------------------------------------------------------------
module tb_pla_sweep_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] exp_y, exp_z;
    logic [3:0]  pla_in;
    logic        pla_y, pla_z;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic        first_fail_valid;
    logic [3:0]  first_fail_vec;
    logic [15:0] cap_y, cap_z;

    // SETTLE_CYCLES = 0 instance
    logic        start0;
    logic [3:0]  pla_in0;
    logic        pla_y0, pla_z0;
    logic        busy0, done0, pass0;
    logic [4:0]  err_count0;
    logic        ffv0;
    logic [3:0]  ffvec0;
    logic [15:0] cap_y0, cap_z0;

    logic [15:0] gold_y = 16'h8801;
    logic [15:0] gold_z = 16'h4020;
    int          mode;   // 0 golden, 1 Y stuck-at-0, 2 Y/Z swapped

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        pla_y = gold_y[pla_in];
        pla_z = gold_z[pla_in];
        if (mode == 1) begin
            pla_y = 1'b0;
        end else if (mode == 2) begin
            pla_y = gold_z[pla_in];
            pla_z = gold_y[pla_in];
        end
    end

    always_comb begin
        pla_y0 = gold_y[pla_in0];
        pla_z0 = gold_z[pla_in0];
    end

    pla_sweep_controller #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .exp_y(exp_y), .exp_z(exp_z), .pla_in(pla_in),
        .pla_y(pla_y), .pla_z(pla_z), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec), .cap_y(cap_y), .cap_z(cap_z)
    );

    pla_sweep_controller #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
        .exp_y(exp_y), .exp_z(exp_z), .pla_in(pla_in0),
        .pla_y(pla_y0), .pla_z(pla_z0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err_count0), .first_fail_valid(ffv0),
        .first_fail_vec(ffvec0), .cap_y(cap_y0), .cap_z(cap_z0)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_sweep(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_results(input string tag, input int n, input int exp_n,
                                 input logic exp_pass, input logic [4:0] exp_err,
                                 input logic exp_ffv, input logic [3:0] exp_ffvec,
                                 input logic [15:0] exp_cy, input logic [15:0] exp_cz);
        checks++;
        if (n !== exp_n) begin
            errors++; $display("FAIL %s latency got %0d want %0d", tag, n, exp_n);
        end
        checks++;
        if ({done, busy, pass} !== {1'b1, 1'b0, exp_pass}) begin
            errors++; $display("FAIL %s done/busy/pass got %b%b%b want 10%b", tag, done, busy, pass, exp_pass);
        end
        checks++;
        if (err_count !== exp_err) begin
            errors++; $display("FAIL %s err_count got %0d want %0d", tag, err_count, exp_err);
        end
        checks++;
        if ({first_fail_valid, first_fail_vec} !== {exp_ffv, exp_ffvec}) begin
            errors++; $display("FAIL %s first_fail got %b/%0d want %b/%0d", tag,
                               first_fail_valid, first_fail_vec, exp_ffv, exp_ffvec);
        end
        checks++;
        if ({cap_y, cap_z} !== {exp_cy, exp_cz}) begin
            errors++; $display("FAIL %s cap got %h/%h want %h/%h", tag, cap_y, cap_z, exp_cy, exp_cz);
        end
        $display("%s: latency=%0d pass=%b err=%0d ffv=%b ffvec=%0d cap_y=%h cap_z=%h",
                 tag, n, pass, err_count, first_fail_valid, first_fail_vec, cap_y, cap_z);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({pla_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec, cap_y, cap_z}
            !== {4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL %s reset values got pla_in=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d cy=%h cz=%h want all zero",
                     tag, pla_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec, cap_y, cap_z);
        end
        $display("%s: reset values checked", tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; start0 = 1'b0; abort = 1'b0;
        exp_y = 16'h8801; exp_z = 16'h4020; mode = 0;
        #3;
        check_reset_values("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_golden();
        int n;
        mode = 0;
        run_sweep(n);
        check_results("golden", n, 64, 1'b1, 5'd0, 1'b0, 4'd0, 16'h8801, 16'h4020);
    endtask

    task automatic test_stuck_y();
        int n;
        mode = 1;
        run_sweep(n);
        check_results("stuck_y0", n, 64, 1'b0, 5'd3, 1'b1, 4'd0, 16'h0000, 16'h4020);
        mode = 0;
    endtask

    // Swapped model; also watches pla_in step through 0..15, 4 cycles each.
    task automatic test_swapped();
        int n;
        int bad = 0;
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
            if (pla_in !== 4'((n - 1) / 4)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL swapped pla_in_sequence got %0d off-schedule cycles want 0", bad);
        end
        check_results("swapped", n, 64, 1'b0, 5'd5, 1'b1, 4'd0, 16'h4020, 16'h8801);
        mode = 0;
    endtask

    task automatic test_abort();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++; $display("FAIL abort busy/done/pass got %b%b%b want 000", busy, done, pass);
        end
        repeat (5) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL abort_stays_idle busy/done got %b%b want 00", busy, done);
        end
        $display("abort: busy=%b done=%b", busy, done);
        // start and abort together: abort wins, nothing starts
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL start_abort_same_cycle busy got %b want 0", busy);
        end
        $display("start+abort: busy=%b", busy);
        run_sweep(n);
        check_results("after_abort", n, 64, 1'b1, 5'd0, 1'b0, 4'd0, 16'h8801, 16'h4020);
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        mode = 1;   // produce nonzero state before reset
        start = 1'b1;
        tick();
        start = 1'b0;
        while (pla_in != 4'd7 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (pla_in !== 4'd7) begin
            errors++; $display("FAIL reach_vector7 pla_in got %0d want 7", pla_in);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("mid_sweep_reset");
        tick();
        rst_n = 1'b1;
        mode = 0;
        tick();
        check_reset_values("after_mid_reset_idle");
    endtask

    task automatic test_start_while_busy();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
            if (n == 10 || n == 30) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        check_results("start_while_busy", n, 64, 1'b1, 5'd0, 1'b0, 4'd0, 16'h8801, 16'h4020);
    endtask

    task automatic test_settle_zero();
        int n = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        while (!done0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL settle0 latency got %0d want 32", n);
        end
        checks++;
        if ({pass0, err_count0, cap_y0, cap_z0} !== {1'b1, 5'd0, 16'h8801, 16'h4020}) begin
            errors++; $display("FAIL settle0 results got pass=%b err=%0d cy=%h cz=%h want 1/0/8801/4020",
                               pass0, err_count0, cap_y0, cap_z0);
        end
        $display("settle0: latency=%0d pass=%b err=%0d", n, pass0, err_count0);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck_y();
        test_swapped();
        test_abort();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_settle_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
